// File: rtl/aline_acq_ctrl.sv
// A-line acquisition controller for the SS-OCT sample RAM.
// Waits for a sweep trigger edge, writes NSAMPLES consecutive addresses into
// one of two RAM banks, then offers the filled bank to the reader.
// Reader handshake: rd_ready is a level meaning "rd_bank holds a complete
// A-line"; the reader answers with a one-cycle rd_ack, which is honoured only
// while rd_ready is high and then frees that bank and advances rd_bank.
module aline_acq_ctrl #(
  parameter int NSAMPLES = 1170,
  parameter int ADDR_W   = 11,
  parameter int HOLDOFF  = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sweep_trig,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              wr_bank,
  output logic              rd_ready,
  output logic              rd_bank,
  input  logic              rd_ack,
  output logic              busy,
  output logic [CNT_W-1:0]  aline_cnt,
  output logic [CNT_W-1:0]  overrun_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_HOLD = 3'd2,
    S_ACQ  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Holdoff counter only needs to hold HOLDOFF-1; keep at least one bit.
  localparam int HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int HOLD_INIT = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NSAMPLES - 1);

  state_t            state_q;
  logic              trig_q;
  logic [HW-1:0]     hold_cnt_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_en_q;
  logic              wr_bank_q;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              rd_ready_q;
  logic              busy_q;
  logic [CNT_W-1:0]  aline_q;
  logic [CNT_W-1:0]  overrun_q;

  logic rise;
  logic ack_ok;
  logic done;

  assign rise   = sweep_trig & ~trig_q;
  assign ack_ok = rd_ack & bank_full_q[rd_bank_q];
  assign done   = (state_q == S_DONE);

  // Bank ownership next state: the reader frees its bank, DONE fills the
  // writer's bank; both may happen on the same edge.
  always_comb begin
    bank_full_d = bank_full_q;
    rd_bank_d   = rd_bank_q;
    if (ack_ok) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end
    if (done) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
  end

  // Capture FSM with registered outputs, bank bookkeeping and counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      hold_cnt_q  <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      rd_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      aline_q     <= '0;
      overrun_q   <= '0;
    end else begin
      trig_q      <= sweep_trig;
      bank_full_q <= bank_full_d;
      rd_bank_q   <= rd_bank_d;
      rd_ready_q  <= bank_full_d[rd_bank_d];
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          // Disable wins over a simultaneous trigger edge.
          if (!enable) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (rise) begin
            if (bank_full_q[wr_bank_q]) begin
              if (overrun_q != {CNT_W{1'b1}}) begin
                overrun_q <= overrun_q + 1'b1;
              end
            end else if (HOLDOFF == 0) begin
              state_q   <= S_ACQ;
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
            end else begin
              state_q    <= S_HOLD;
              hold_cnt_q <= HW'(HOLD_INIT);
            end
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == '0) begin
            state_q   <= S_ACQ;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        S_ACQ: begin
          // Compare against the last address so a full 2^ADDR_W line works.
          if (wr_addr_q == LAST_ADDR) begin
            state_q   <= S_DONE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
          end else begin
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end
        S_DONE: begin
          wr_bank_q <= ~wr_bank_q;
          aline_q   <= aline_q + 1'b1;
          if (enable) begin
            state_q <= S_ARM;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          wr_en_q   <= 1'b0;
          wr_addr_q <= '0;
        end
      endcase
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_en       = wr_en_q;
  assign wr_bank     = wr_bank_q;
  assign rd_ready    = rd_ready_q;
  assign rd_bank     = rd_bank_q;
  assign busy        = busy_q;
  assign aline_cnt   = aline_q;
  assign overrun_cnt = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aline_acq_ctrl.sv
// Bench for aline_acq_ctrl: an 8-sample / holdoff-2 instance driven from a
// vector table plus corner sequences, and a 2048-sample / holdoff-0 instance.
module tb_aline_acq_ctrl;

  localparam int NA = 8;
  localparam int HA = 2;
  localparam int AWA = 3;
  localparam int NB = 2048;
  localparam int AWB = 11;
  localparam int CW = 16;
  localparam int QW = 32 + 1 + AWA;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  int   cyc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT A ----------------
  logic           enable_a, trig_a, ack_a;
  logic [AWA-1:0] wr_addr_a;
  logic           wr_en_a, wr_bank_a, rd_ready_a, rd_bank_a, busy_a;
  logic [CW-1:0]  aline_a, ovr_a;
  logic [2:0]     dbg_a;

  aline_acq_ctrl #(.NSAMPLES(NA), .ADDR_W(AWA), .HOLDOFF(HA), .CNT_W(CW)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .enable(enable_a), .sweep_trig(trig_a),
    .wr_addr(wr_addr_a), .wr_en(wr_en_a), .wr_bank(wr_bank_a),
    .rd_ready(rd_ready_a), .rd_bank(rd_bank_a), .rd_ack(ack_a), .busy(busy_a),
    .aline_cnt(aline_a), .overrun_cnt(ovr_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B ----------------
  logic           enable_b, trig_b, ack_b;
  logic [AWB-1:0] wr_addr_b;
  logic           wr_en_b, wr_bank_b, rd_ready_b, rd_bank_b, busy_b;
  logic [CW-1:0]  aline_b, ovr_b;
  logic [2:0]     dbg_b;

  aline_acq_ctrl #(.NSAMPLES(NB), .ADDR_W(AWB), .HOLDOFF(0), .CNT_W(CW)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable_b), .sweep_trig(trig_b),
    .wr_addr(wr_addr_b), .wr_en(wr_en_b), .wr_bank(wr_bank_b),
    .rd_ready(rd_ready_b), .rd_bank(rd_bank_b), .rd_ack(ack_b), .busy(busy_b),
    .aline_cnt(aline_b), .overrun_cnt(ovr_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  logic [QW-1:0] exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected writes for a trigger sampled at edge t: one entry per RAM edge.
  task automatic push_writes(input int t, input logic bank, input int count);
    for (int i = 0; i < count; i++) begin
      exp_q.push_back({32'(t + 1 + HA + i), bank, AWA'(i)});
    end
  endtask

  // Each negedge shows what the RAM samples on the next rising edge.
  always @(negedge clock) begin
    if (wr_en_a) begin
      logic [QW-1:0] got;
      logic [QW-1:0] exp;
      got = {32'(cyc + 1), wr_bank_a, wr_addr_a};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=edge%0d/bank%0d/addr%0d required=none",
                 cyc + 1, wr_bank_a, wr_addr_a);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL write actual=edge%0d/bank%0d/addr%0d required=edge%0d/bank%0d/addr%0d",
                   got[QW-1:AWA+1], got[AWA], got[AWA-1:0],
                   exp[QW-1:AWA+1], exp[AWA], exp[AWA-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Raise trig_a for one cycle; returns the edge index that samples it.
  task automatic pulse_trig_a(output int t);
    trig_a = 1'b1;
    t = cyc + 1;
    tick();
    trig_a = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic b, input logic rr, input logic rb,
                       input logic wb, input int al, input int ov);
    chk({tag, "_busy"}, busy_a, b);
    chk({tag, "_rd_ready"}, rd_ready_a, rr);
    chk({tag, "_rd_bank"}, rd_bank_a, rb);
    chk({tag, "_wr_bank"}, wr_bank_a, wb);
    chk({tag, "_aline"}, aline_a, al);
    chk({tag, "_overrun"}, ovr_a, ov);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic trig;
    logic ack;
    logic cap;
    logic exp_rd_ready;
    logic exp_rd_bank;
    logic exp_wr_bank;
    int   exp_aline;
    int   exp_ovr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int t;
    int first_key, last_key, nwr, addr_err, exp_addr;
    bit found;

    vecs[0]  = '{1, 0, 1, 1, 0, 1, 1, 0};  // capture bank 0
    vecs[1]  = '{1, 0, 1, 1, 0, 0, 2, 0};  // capture bank 1, both full
    vecs[2]  = '{1, 0, 0, 1, 0, 0, 2, 1};  // no free bank: overrun
    vecs[3]  = '{0, 1, 0, 1, 1, 0, 2, 1};  // ack bank 0
    vecs[4]  = '{0, 1, 0, 0, 0, 0, 2, 1};  // ack bank 1, none full
    vecs[5]  = '{1, 0, 1, 1, 0, 1, 3, 1};  // capture bank 0 again
    vecs[6]  = '{0, 1, 0, 0, 1, 1, 3, 1};  // ack bank 0
    vecs[7]  = '{1, 0, 1, 1, 1, 0, 4, 1};  // capture bank 1
    vecs[8]  = '{1, 0, 1, 1, 1, 1, 5, 1};  // capture bank 0
    vecs[9]  = '{1, 0, 0, 1, 1, 1, 5, 2};  // overrun again
    vecs[10] = '{0, 1, 0, 1, 0, 1, 5, 2};  // ack bank 1
    vecs[11] = '{0, 1, 0, 0, 1, 1, 5, 2};  // ack bank 0
    vecs[12] = '{0, 1, 0, 0, 1, 1, 5, 2};  // ack while not ready: ignored

    total = 0;
    bad = 0;
    cyc = 0;
    reset_n = 1'b0;
    enable_a = 1'b0; trig_a = 1'b0; ack_a = 1'b0;
    enable_b = 1'b0; trig_b = 1'b0; ack_b = 1'b0;
    ticks(3);

    // Reset state.
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_addr", wr_addr_a, 0);
    chk_a("rst", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    // Full-depth line, no holdoff.
    enable_b = 1'b1;
    ticks(2);
    trig_b = 1'b1;
    t = cyc + 1;
    tick();
    trig_b = 1'b0;
    first_key = -1; last_key = -1; nwr = 0; addr_err = 0; exp_addr = 0;
    for (int i = 0; i < NB + 40; i++) begin
      if (wr_en_b) begin
        if (first_key < 0) first_key = cyc + 1;
        last_key = cyc + 1;
        if (wr_addr_b !== AWB'(exp_addr)) addr_err++;
        exp_addr++;
        nwr++;
      end
      tick();
    end
    chk("b_first_write", first_key, t + 1);
    chk("b_last_write", last_key, t + NB);
    chk("b_write_count", nwr, NB);
    chk("b_addr_errors", addr_err, 0);
    chk("b_addr_after", wr_addr_b, 0);
    chk("b_aline", aline_b, 1);
    chk("b_rd_ready", rd_ready_b, 1);
    chk("b_wr_bank", wr_bank_b, 1);
    enable_b = 1'b0;

    // Idle-to-arm, then the table.
    chk("a_idle_busy", busy_a, 0);
    enable_a = 1'b1;
    ticks(2);
    chk("a_arm_busy", busy_a, 1);
    for (int i = 0; i < 13; i++) begin
      trig_a = vecs[i].trig;
      ack_a  = vecs[i].ack;
      if (vecs[i].trig && vecs[i].cap) push_writes(cyc + 1, ~vecs[i].exp_wr_bank, NA);
      tick();
      trig_a = 1'b0;
      ack_a  = 1'b0;
      ticks(20);
      chk_a($sformatf("vec%0d", i), 1, vecs[i].exp_rd_ready, vecs[i].exp_rd_bank,
            vecs[i].exp_wr_bank, vecs[i].exp_aline, vecs[i].exp_ovr);
    end

    // Extra trigger edges during HOLDOFF and ACQ must be ignored.
    pulse_trig_a(t);
    push_writes(t, 1'b1, NA);
    tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0; tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0; tick();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    ticks(20);
    chk_a("retrig", 1, 1, 1, 0, 6, 2);

    // Enable dropped at address 3: line completes, then IDLE.
    pulse_trig_a(t);
    push_writes(t, 1'b0, NA);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (wr_en_a && wr_addr_a == 3) found = 1;
      else tick();
    end
    chk("en_drop_reached_addr3", found, 1);
    enable_a = 1'b0;
    ticks(15);
    chk_a("en_drop", 0, 1, 1, 1, 7, 2);
    chk("en_drop_state", dbg_a, 0);

    // Trigger and ack on the same edge: the ack does not free the bank in time.
    enable_a = 1'b1;
    ticks(2);
    trig_a = 1'b1;
    ack_a  = 1'b1;
    tick();
    trig_a = 1'b0;
    ack_a  = 1'b0;
    ticks(20);
    chk_a("trig_ack_same", 1, 1, 0, 1, 7, 3);

    // Reset at address 3 aborts the line.
    pulse_trig_a(t);
    push_writes(t, 1'b1, 4);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (wr_en_a && wr_addr_a == 3) found = 1;
      else tick();
    end
    chk("rst_mid_reached_addr3", found, 1);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_wr_en", wr_en_a, 0);
    chk_a("rst_mid", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    ticks(2);
    // Both banks must be free after reset: two captures with no ack.
    for (int k = 0; k < 2; k++) begin
      pulse_trig_a(t);
      push_writes(t, 1'(k), NA);
      ticks(20);
    end
    chk_a("post_rst", 1, 1, 0, 0, 2, 0);

    ticks(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
